// File: rtl/vinstru_seq.sv
// Instrument power-up / capture sequencer: settle, reset pulse, gap, run pulse, wait for done, repeat.
// Latency: vi_enable one cycle after an accepted start; vi_done counted two cycles after it rises.
// Backpressure: none; start is a single-cycle request, ignored while busy; abort wins over everything.
//
// Ports:
//   clk, resetn            clock and asynchronous active-low reset
//   start, abort           begin a sequence (IDLE only) / stop it immediately
//   num_captures, holdoff,
//   timeout                sequence settings, latched on an accepted start
//   vi_enable, vi_reset,
//   vi_run, vi_done        instrument control (registered) and completion level
//   busy, capture_count,
//   irq, err_timeout,
//   aborted                status: in-progress, captures done, done/error pulse, sticky flags
module vinstru_seq #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int RST_CYCLES    = 10,
  parameter int GAP_CYCLES    = 10,
  parameter int RUN_CYCLES    = 100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] num_captures,
  input  logic [15:0] holdoff,
  input  logic [31:0] timeout,
  output logic        vi_enable,
  output logic        vi_reset,
  output logic        vi_run,
  input  logic        vi_done,
  output logic        busy,
  output logic [15:0] capture_count,
  output logic        irq,
  output logic        err_timeout,
  output logic        aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RST,
    S_GAP,
    S_RUN,
    S_WAIT_DONE,
    S_HOLDOFF,
    S_FINISH
  } state_t;

  // Counter load values: a phase of N cycles loads N-1 and leaves when it reads 0.
  localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] RST_LD    = 32'(RST_CYCLES - 1);
  localparam logic [31:0] GAP_LD    = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] RUN_LD    = 32'(RUN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] num_q, num_d;
  logic [15:0] holdoff_q, holdoff_d;
  logic [31:0] timeout_q, timeout_d;
  logic [15:0] cap_q, cap_d;
  logic        done_q, done_d;
  logic        done_prev_q, done_prev_d;
  logic        vi_enable_q, vi_enable_d;
  logic        vi_reset_q, vi_reset_d;
  logic        vi_run_q, vi_run_d;
  logic        irq_q, irq_d;
  logic        err_q, err_d;
  logic        aborted_q, aborted_d;

  logic        done_evt;
  logic        cnt_zero;
  logic [16:0] cap_inc;
  logic        cap_hit;

  // Completion is a rising edge of the registered vi_done, so a level that
  // was already high before WAIT_DONE never produces an event.
  assign done_evt = done_q & ~done_prev_q;
  assign cnt_zero = (cnt_q == 32'd0);
  // One extra bit so a count of 65535 compares cleanly without wrapping.
  assign cap_inc  = {1'b0, cap_q} + 17'd1;
  assign cap_hit  = (cap_inc == {1'b0, num_q});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    holdoff_d   = holdoff_q;
    timeout_d   = timeout_q;
    cap_d       = cap_q;
    err_d       = err_q;
    aborted_d   = aborted_q;
    irq_d       = 1'b0;
    done_d      = vi_done;
    done_prev_d = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && (num_captures != 16'd0)) begin
          num_d     = num_captures;
          holdoff_d = holdoff;
          timeout_d = timeout;
          cap_d     = 16'd0;
          err_d     = 1'b0;
          aborted_d = 1'b0;
          state_d   = S_SETTLE;
          cnt_d     = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (cnt_zero) begin
          state_d = S_RST;
          cnt_d   = RST_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_RST: begin
        if (cnt_zero) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          state_d = S_RUN;
          cnt_d   = RUN_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_RUN: begin
        if (cnt_zero) begin
          state_d = S_WAIT_DONE;
          // Value is only consulted when the timeout is non-zero.
          cnt_d   = timeout_q - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_WAIT_DONE: begin
        if (done_evt) begin
          cap_d = cap_inc[15:0];
          if (cap_hit) begin
            state_d = S_FINISH;
          end else if (holdoff_q == 16'd0) begin
            state_d = S_RST;
            cnt_d   = RST_LD;
          end else begin
            state_d = S_HOLDOFF;
            cnt_d   = {16'd0, holdoff_q} - 32'd1;
          end
        end else if ((timeout_q != 32'd0) && cnt_zero) begin
          err_d   = 1'b1;
          irq_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_HOLDOFF: begin
        if (cnt_zero) begin
          state_d = S_RST;
          cnt_d   = RST_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the phase logic decided, including a
    // completion or timeout landing on the same edge.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_d     = 32'd0;
      cap_d     = cap_q;
      err_d     = err_q;
      irq_d     = 1'b0;
      aborted_d = 1'b1;
    end

    if (state_d == S_FINISH) begin
      irq_d = 1'b1;
    end

    // Instrument controls are registered copies of the next state.
    vi_enable_d = (state_d != S_IDLE);
    vi_reset_d  = (state_d == S_RST);
    vi_run_d    = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 32'd0;
      num_q       <= 16'd0;
      holdoff_q   <= 16'd0;
      timeout_q   <= 32'd0;
      cap_q       <= 16'd0;
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
      vi_enable_q <= 1'b0;
      vi_reset_q  <= 1'b0;
      vi_run_q    <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      holdoff_q   <= holdoff_d;
      timeout_q   <= timeout_d;
      cap_q       <= cap_d;
      done_q      <= done_d;
      done_prev_q <= done_prev_d;
      vi_enable_q <= vi_enable_d;
      vi_reset_q  <= vi_reset_d;
      vi_run_q    <= vi_run_d;
      irq_q       <= irq_d;
      err_q       <= err_d;
      aborted_q   <= aborted_d;
    end
  end

  assign vi_enable     = vi_enable_q;
  assign vi_reset      = vi_reset_q;
  assign vi_run        = vi_run_q;
  assign busy          = (state_q != S_IDLE);
  assign capture_count = cap_q;
  assign irq           = irq_q;
  assign err_timeout   = err_q;
  assign aborted       = aborted_q;

endmodule

// File: tb/tb_vinstru_seq.sv
// Testbench for vinstru_seq: timeline reference model, randomized sequences.
// Periods are numbered from the one in which start is high (period 0).
// Outputs are sampled on the falling edge, inputs driven right after sampling.
module tb_vinstru_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [15:0] num_captures;
  logic [15:0] holdoff;
  logic [31:0] timeout;
  logic        vi_enable;
  logic        vi_reset;
  logic        vi_run;
  logic        vi_done;
  logic        busy;
  logic [15:0] capture_count;
  logic        irq;
  logic        err_timeout;
  logic        aborted;

  int errors = 0;
  int checks = 0;

  // Bench-side memory of what the model says the sticky/status state is.
  logic [15:0] prev_count = 16'd0;
  logic        prev_err   = 1'b0;
  logic        prev_ab    = 1'b0;

  always #5 clk = ~clk;

  vinstru_seq dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .abort        (abort),
    .num_captures (num_captures),
    .holdoff      (holdoff),
    .timeout      (timeout),
    .vi_enable    (vi_enable),
    .vi_reset     (vi_reset),
    .vi_run       (vi_run),
    .vi_done      (vi_done),
    .busy         (busy),
    .capture_count(capture_count),
    .irq          (irq),
    .err_timeout  (err_timeout),
    .aborted      (aborted)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one sequence and checks every period against a timeline model.
  // mode 0: vi_done pulses per capture after d_i cycles of WAIT_DONE
  // mode 1: vi_done never rises (timeout expected)
  // mode 2: vi_done held high throughout (never counts, timeout expected)
  // abort_r / xs_r: period of an abort / ignored extra start (-1 = none)
  task automatic test_sequence(input string name, input int n, input int hold,
                               input int tmo, input int mode, input int abort_r,
                               input int xs_r, input int d0, input int d1, input int d2);
    int rr[3];
    int ww[3];
    int cc[3];
    int dd[3];
    int endr, kind, nph, e_cnt;
    logic e_busy, e_rst, e_run, e_irq, e_err, e_ab, drv_done;
    logic [6:0] exp_v, obs_v;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    rr[0] = 1 + 1000;
    for (int i = 0; i < 3; i++) begin
      ww[i] = rr[i] + 10 + 10 + 100;
      cc[i] = ww[i] + dd[i] + 2;
      if (i < 2) rr[i+1] = cc[i] + hold;
    end
    if (mode != 0) begin
      kind = 1; endr = ww[0] + tmo; nph = 1;
    end else begin
      kind = 0; endr = cc[n-1] + 1; nph = n;
    end
    if (abort_r >= 1 && abort_r + 1 < endr) begin
      kind = 2; endr = abort_r + 1;
    end
    e_cnt = 0; e_err = 1'b0; e_ab = 1'b0;
    for (int r = 0; r <= endr + 4; r++) begin
      @(negedge clk);
      e_busy = (r >= 1) && (r < endr);
      e_rst = 1'b0; e_run = 1'b0; e_cnt = 0;
      for (int i = 0; i < nph; i++) begin
        if (e_busy && r >= rr[i] && r <= rr[i] + 9) e_rst = 1'b1;
        if (e_busy && r >= rr[i] + 20 && r <= rr[i] + 119) e_run = 1'b1;
        if (mode == 0 && cc[i] < endr && cc[i] <= r) e_cnt++;
      end
      e_irq = (kind == 0 && r == endr - 1) || (kind == 1 && r == endr);
      e_err = (kind == 1 && r >= endr);
      e_ab  = (kind == 2 && r >= endr);
      if (r == 0) begin
        obs_v = {vi_enable, vi_reset, vi_run, busy, irq, 2'b00};
        if (obs_v !== 7'd0) begin
          errors++;
          $display("FAIL %s idle-before-start: got %b want 0000000", name, obs_v);
        end
        checks++;
        if (capture_count !== prev_count) begin
          errors++;
          $display("FAIL %s count-hold: got %0d want %0d", name, capture_count, prev_count);
        end
        checks++;
      end else begin
        exp_v = {e_busy, e_rst, e_run, e_busy, e_irq, e_err, e_ab};
        obs_v = {vi_enable, vi_reset, vi_run, busy, irq, err_timeout, aborted};
        if (obs_v !== exp_v) begin
          errors++;
          $display("FAIL %s outputs(en,rst,run,busy,irq,err,ab) r=%0d: got %b want %b",
                   name, r, obs_v, exp_v);
        end
        checks++;
        if (capture_count !== 16'(e_cnt)) begin
          errors++;
          $display("FAIL %s capture_count r=%0d: got %0d want %0d", name, r, capture_count, e_cnt);
        end
        checks++;
      end
      // Drive inputs for this period; settings are scrambled after the start
      // period so any failure to latch them shows up.
      drv_done = 1'b0;
      if (mode == 2) drv_done = 1'b1;
      if (mode == 0)
        for (int i = 0; i < n; i++)
          if (r >= ww[i] + dd[i] && r < cc[i]) drv_done = 1'b1;
      vi_done = drv_done;
      abort   = (r == abort_r);
      start   = (r == 0) || (r == xs_r && r < endr);
      if (r == 0) begin
        num_captures = 16'(n);
        holdoff      = 16'(hold);
        timeout      = 32'(tmo);
      end else begin
        num_captures = 16'($urandom_range(0, 65535));
        holdoff      = 16'($urandom_range(0, 65535));
        timeout      = $urandom;
      end
    end
    start = 1'b0; abort = 1'b0; vi_done = 1'b0;
    prev_count = 16'(e_cnt);
    prev_err   = e_err;
    prev_ab    = e_ab;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [6:0] obs_v;
    resetn = 1'b0; start = 1'b0; abort = 1'b0; vi_done = 1'b0;
    num_captures = 16'd0; holdoff = 16'd0; timeout = 32'd0;
    repeat (3) @(negedge clk);
    obs_v = {vi_enable, vi_reset, vi_run, busy, irq, err_timeout, aborted};
    if (obs_v !== 7'd0) begin
      errors++;
      $display("FAIL reset outputs: got %b want 0000000", obs_v);
    end
    checks++;
    if (capture_count !== 16'd0) begin
      errors++;
      $display("FAIL reset capture_count: got %0d want 0", capture_count);
    end
    checks++;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    obs_v = {vi_enable, vi_reset, vi_run, busy, irq, err_timeout, aborted};
    if (obs_v !== 7'd0) begin
      errors++;
      $display("FAIL after-reset idle: got %b want 0000000", obs_v);
    end
    checks++;
  endtask

  // start with num_captures=0 and abort in IDLE must both be no-ops.
  task automatic test_idle_noops();
    logic [4:0] obs_v;
    @(negedge clk);
    start = 1'b1; num_captures = 16'd0; holdoff = 16'd5; timeout = 32'd7;
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      obs_v = {vi_enable, vi_reset, vi_run, busy, irq};
      if (obs_v !== 5'd0) begin
        errors++;
        $display("FAIL idle_noops outputs k=%0d: got %b want 00000", k, obs_v);
      end
      checks++;
      if ({capture_count, err_timeout, aborted} !== {prev_count, prev_err, prev_ab}) begin
        errors++;
        $display("FAIL idle_noops status k=%0d: got cnt=%0d err=%b ab=%b want cnt=%0d err=%b ab=%b",
                 k, capture_count, err_timeout, aborted, prev_count, prev_err, prev_ab);
      end
      checks++;
    end
  endtask

  // Asynchronous reset in the middle of HOLDOFF, then no resumption.
  task automatic test_reset_holdoff();
    logic [6:0] obs_v;
    // n=2, holdoff=40, done after 10 cycles of WAIT_DONE: HOLDOFF spans 1133..1172.
    for (int r = 0; r < 1150; r++) begin
      @(negedge clk);
      start = (r == 0);
      num_captures = 16'd2; holdoff = 16'd40; timeout = 32'd0;
      vi_done = (r >= 1131 && r < 1133);
    end
    start = 1'b0; vi_done = 1'b0;
    @(negedge clk);
    obs_v = {vi_enable, vi_reset, vi_run, busy, irq, err_timeout, aborted};
    if (obs_v !== 7'b1001000 || capture_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_holdoff in-holdoff: got %b cnt=%0d want 1001000 cnt=1", obs_v, capture_count);
    end
    checks++;
    #1 resetn = 1'b0;
    #1;
    obs_v = {vi_enable, vi_reset, vi_run, busy, irq, err_timeout, aborted};
    if (obs_v !== 7'd0 || capture_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_holdoff async-clear: got %b cnt=%0d want 0000000 cnt=0", obs_v, capture_count);
    end
    checks++;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      obs_v = {vi_enable, vi_reset, vi_run, busy, irq, err_timeout, aborted};
      if (obs_v !== 7'd0) begin
        errors++;
        $display("FAIL reset_holdoff no-resume k=%0d: got %b want 0000000", k, obs_v);
      end
      checks++;
    end
    prev_count = 16'd0; prev_err = 1'b0; prev_ab = 1'b0;
  endtask

  task automatic test_random();
    int n, hold, tmo;
    for (int it = 0; it < 3; it++) begin
      n    = $urandom_range(1, 3);
      hold = (it == 0) ? 0 : $urandom_range(0, 30);
      tmo  = ($urandom_range(0, 1) == 1) ? $urandom_range(100, 400) : 0;
      test_sequence("random", n, hold, tmo, 0, -1, $urandom_range(2, 900),
                    $urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(0, 60));
    end
  endtask

  initial begin
    test_reset();
    test_sequence("single", 1, 0, 0, 0, -1, -1, 50, 0, 0);
    test_sequence("multi", 3, 20, 0, 0, -1, 500, 5, 17, 33);
    test_sequence("timeout", 1, 0, 500, 1, -1, -1, 0, 0, 0);
    test_sequence("abort_run", 2, 5, 0, 0, 1050, -1, 10, 10, 0);
    // Abort lands on the edge that would count the completion (1121+20+1).
    test_sequence("abort_vs_done", 1, 0, 0, 0, 1142, -1, 20, 0, 0);
    test_random();
    test_sequence("done_high", 1, 0, 300, 2, -1, -1, 0, 0, 0);
    test_idle_noops();
    test_reset_holdoff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vinstru_seq.md
VINSTRU_SEQ -- requirements
Module: vinstru_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1000: cycles vi_enable is held before the first reset pulse.
REQ-002 Parameter RST_CYCLES, default 10: width of the vi_reset pulse.
REQ-003 Parameter GAP_CYCLES, default 10: low cycles between vi_reset falling and vi_run rising.
REQ-004 Parameter RUN_CYCLES, default 100: width of the vi_run pulse.
REQ-005 Ports, in this order:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a sequence.
- abort  in  1  stop the sequence immediately.
- num_captures  in  16  captures per sequence.
- holdoff  in  16  idle cycles between captures.
- timeout  in  32  maximum cycles to wait for done; 0 = no timeout.
- vi_enable  out  1  instrument enable.
- vi_reset  out  1  instrument reset, active high.
- vi_run  out  1  instrument run.
- vi_done  in  1  instrument capture complete, level.
- busy  out  1  sequence in progress.
- capture_count  out  16  captures completed in the current or last sequence.
- irq  out  1  one-cycle completion/error pulse.
- err_timeout  out  1  sticky timeout flag.
- aborted  out  1  sticky abort flag.

Function
REQ-006 States SHALL be IDLE, SETTLE, RST, GAP, RUN, WAIT_DONE, HOLDOFF and FINISH, with one shared 32-bit down-counter.
REQ-007 In IDLE, start=1 with num_captures!=0 SHALL do all of the following on that edge:
- latch num_captures, holdoff and timeout;
- clear capture_count, err_timeout and aborted;
- enter SETTLE.
REQ-008 In IDLE, start=1 with num_captures=0 SHALL be ignored: no state change and no irq.
REQ-009 start SHALL be ignored in every state other than IDLE.
REQ-010 vi_enable SHALL be 1 in every state except IDLE; busy SHALL equal (state!=IDLE).
REQ-011 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter RST.
REQ-012 vi_reset SHALL be 1 for exactly RST_CYCLES cycles while in RST, then the block SHALL enter GAP.
REQ-013 GAP SHALL last GAP_CYCLES cycles, then enter RUN.
REQ-014 vi_run SHALL be 1 for exactly RUN_CYCLES cycles while in RUN, then the block SHALL enter WAIT_DONE.
REQ-015 vi_enable, vi_reset and vi_run SHALL be driven directly from registers with no combinational path from inputs.
REQ-016 vi_done SHALL be registered once; a 0->1 edge on the registered copy SHALL count as a completion event.
REQ-017 A vi_done level already high on entry to WAIT_DONE SHALL NOT count as a completion event.
REQ-018 On a completion event in WAIT_DONE, capture_count SHALL increment by 1 on the same edge.
REQ-019 After the increment: if the new capture_count equals the latched num_captures, enter FINISH; otherwise enter HOLDOFF.
REQ-020 HOLDOFF SHALL last the latched holdoff cycles (0 = zero cycles, go directly to RST), then enter RST; SETTLE SHALL NOT be repeated within a sequence.
REQ-021 When the latched timeout!=0 and WAIT_DONE has lasted timeout cycles with no completion event:
- set err_timeout=1;
- pulse irq;
- enter IDLE.
REQ-022 FINISH SHALL last one cycle, assert irq=1 during it, then enter IDLE.
REQ-023 abort=1 in any non-IDLE state SHALL, on that edge:
- enter IDLE;
- drive vi_enable, vi_reset and vi_run to 0 on the following cycle;
- set aborted=1;
- generate no irq.
REQ-024 abort in IDLE SHALL have no effect.
REQ-025 abort and a completion event in the same cycle: abort SHALL win and capture_count SHALL NOT increment.
REQ-026 capture_count SHALL hold its value in IDLE until the next accepted start.
REQ-027 Counter comparisons SHALL be unsigned; a latched num_captures of 65535 SHALL complete without capture_count wrap-around.

Reset
REQ-028 While resetn=0 the block SHALL be in state IDLE asynchronously.
REQ-029 While resetn=0 all outputs SHALL be 0, and the counter and vi_done register SHALL be 0.
REQ-030 Deassertion of resetn mid-sequence SHALL leave the block in IDLE; it SHALL NOT resume the sequence.
REQ-031 resetn SHALL be deasserted synchronously to clk by the integrator.

Verification
REQ-032 Single capture: num_captures=1, defaults, vi_done rises 50 cycles after vi_run falls.
- vi_enable rises 1 cycle after start.
- vi_reset is high for cycles 1001-1010.
- vi_run is high for cycles 1021-1120.
- irq pulses once, capture_count=1, busy=0.
REQ-033 Multi capture: num_captures=3, holdoff=20.
- Exactly three vi_reset/vi_run pulse pairs.
- 20-cycle holdoff between each done and the next vi_reset.
- Final capture_count=3, one irq.
REQ-034 Timeout: timeout=500, vi_done held 0.
- err_timeout=1 and irq pulse exactly 500 cycles after WAIT_DONE entry.
- vi_enable=0 on the next cycle.
REQ-035 Abort during RUN (cycle 1050 after start):
- vi_run and vi_enable are 0 on the next cycle.
- aborted=1, no irq, capture_count=0.
REQ-036 Edge cases:
- start with num_captures=0: no state change.
- vi_done held high throughout: no completion counted.
- resetn pulsed low in HOLDOFF: all outputs 0 immediately, IDLE after release.
